// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin fetch/data arbiter in front of a single-port synchronous RAM
module mem_arbiter #(
    parameter int AW = 14
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_req,
    input  logic [31:0]   i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [31:0]   i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_wstrb,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_LOAD  = 2'd2
    } owner_t;

    owner_t      owner_q, owner_d;
    logic        last_d_q;
    logic [31:0] i_hold_q, d_hold_q;
    logic        misaligned;
    logic        d_access;

    // Fetch addresses are word-aligned; high address bits wrap inside the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2]};

    always_comb begin
        misaligned = 1'b0;
        if (d_wstrb == 4'b1111 && d_addr[1:0] != 2'b00)
            misaligned = 1'b1;
        if ((d_wstrb == 4'b0011 || d_wstrb == 4'b1100) && d_addr[0])
            misaligned = 1'b1;
    end

    // Contested cycles go to whoever was not granted last; reset makes fetch win first.
    always_comb begin
        i_gnt = resetn && i_req && (!d_req || last_d_q);
        d_gnt = resetn && d_req && !i_gnt;
    end

    assign d_access = d_gnt && !misaligned;

    always_comb begin
        owner_d = OWN_NONE;
        if (i_gnt)
            owner_d = OWN_FETCH;
        else if (d_access && !d_we)
            owner_d = OWN_LOAD;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            owner_q  <= OWN_NONE;
            last_d_q <= 1'b1;
            i_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            owner_q <= owner_d;
            if (i_gnt || d_gnt)
                last_d_q <= d_gnt;
            if (i_rvalid)
                i_hold_q <= mem_rdata;
            if (d_rvalid)
                d_hold_q <= mem_rdata;
        end
    end

    // Outputs are gated by resetn so a reset cycle shows all-zero outputs immediately.
    always_comb begin
        i_rvalid  = resetn && (owner_q == OWN_FETCH);
        d_rvalid  = resetn && (owner_q == OWN_LOAD);
        i_rdata   = '0;
        d_rdata   = '0;
        if (resetn) begin
            i_rdata = i_rvalid ? mem_rdata : i_hold_q;
            d_rdata = d_rvalid ? mem_rdata : d_hold_q;
        end
        d_err     = d_gnt && misaligned;
        mem_en    = i_gnt || d_access;
        mem_we    = (d_access && d_we) ? d_wstrb : 4'b0000;
        mem_addr  = '0;
        if (i_gnt)
            mem_addr = i_addr[AW+1:2];
        else if (d_access)
            mem_addr = d_addr[AW+1:2];
        mem_wdata = resetn ? d_wdata : '0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter against a behavioural model
module tb_mem_arbiter;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          i_req, i_gnt, i_rvalid;
    logic [31:0]   i_addr, i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic [3:0]    d_wstrb;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    logic [31:0] ram [0:(1<<AW)-1];
    logic [31:0] model_mem [0:(1<<AW)-1];
    logic [3:0]  strbs [7] = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic idle();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 0;
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0; i_req = 1; d_req = 1; d_we = 1; d_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, mem_en} !== 6'b0 || mem_we !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got gnt=%b%b rv=%b%b err=%b en=%b we=%h, want all 0",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, mem_en, mem_we);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got i=%h d=%h, want 0", i_rdata, d_rdata);
        end
        idle();
        @(posedge clk); #1 resetn = 1;
    endtask

    task automatic test_fetch();
        do_reset();
        ram[8'h10] = 32'hDEADBEEF;
        i_req = 1; i_addr = 32'h40;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL fetch_grant: got i_gnt=%b d_gnt=%b en=%b addr=%h, want 1 0 1 10",
                     i_gnt, d_gnt, mem_en, mem_addr);
        end
        @(posedge clk); #1 idle();
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b1 || d_rvalid !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL fetch_data: got rv=%b/%b data=%h, want 1/0 deadbeef", i_rvalid, d_rvalid, i_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_contested();
        do_reset();
        ram[8'h20] = 32'hA0000020;
        ram[8'h21] = 32'hA0000021;
        i_req = 1; i_addr = 32'h80; d_req = 1; d_we = 0; d_addr = 32'h84; d_wstrb = 4'hF;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle();
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (i_gnt !== (k % 2 == 0) || d_gnt !== (k % 2 == 1)) begin
                    errors++;
                    $display("FAIL contested_grant[%0d]: got i=%b d=%b, want i=%b", k, i_gnt, d_gnt, k % 2 == 0);
                end
            end
            if (k > 0) begin
                checks++;
                if (i_rvalid !== ((k-1) % 2 == 0) || d_rvalid !== ((k-1) % 2 == 1) ||
                    (i_rvalid && i_rdata !== 32'hA0000020) || (d_rvalid && d_rdata !== 32'hA0000021)) begin
                    errors++;
                    $display("FAIL contested_rvalid[%0d]: got rv=%b/%b data=%h/%h", k, i_rvalid, d_rvalid, i_rdata, d_rdata);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_byte_write();
        do_reset();
        ram[8'h11] = 32'h11112222;
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wstrb = 4'b0100; d_wdata = 32'h00AB0000;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 4'b0100 || d_err !== 1'b0 || mem_en !== 1'b1) begin
            errors++;
            $display("FAIL byte_write: got gnt=%b we=%b err=%b en=%b, want 1 0100 0 1", d_gnt, mem_we, d_err, mem_en);
        end
        @(posedge clk); #1;
        d_we = 0; d_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || mem_we !== 4'b0) begin
            errors++;
            $display("FAIL write_no_rvalid: got rv=%b gnt=%b we=%b, want 0 1 0", d_rvalid, d_gnt, mem_we);
        end
        @(posedge clk); #1 idle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 32'h11AB2222) begin
            errors++;
            $display("FAIL byte_readback: got rv=%b data=%h, want 1 11ab2222", d_rvalid, d_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_misaligned();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h42; d_wstrb = 4'hF;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || d_err !== 1'b1 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL misaligned: got gnt=%b err=%b en=%b, want 1 1 0", d_gnt, d_err, mem_en);
        end
        @(posedge clk); #1 idle();
        @(negedge clk);
        checks++;
        if (d_rvalid !== 1'b0 || d_err !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_after: got rv=%b err=%b, want 0 0", d_rvalid, d_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_after_grant();
        do_reset();
        ram[8'h05] = 32'h5555AAAA;
        i_req = 1; i_addr = 32'h14;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_grant: got i_gnt=%b, want 1", i_gnt);
        end
        @(posedge clk); #1;
        resetn = 0;
        @(negedge clk);
        checks++;
        if ({i_gnt, d_gnt, i_rvalid, d_rvalid, d_err, mem_en} !== 6'b0 || mem_we !== 4'b0 ||
            i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_suppress: got gnt=%b%b rv=%b%b en=%b rdata=%h, want all 0",
                     i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, i_rdata);
        end
        idle();
        @(posedge clk); #1 resetn = 1;
        @(negedge clk);
        checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_after: got rv=%b data=%h, want 0 0", i_rvalid, i_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_data_then_contest();
        do_reset();
        d_req = 1; d_we = 0; d_addr = 32'h10; d_wstrb = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin
                errors++;
                $display("FAIL data_only[%0d]: got d=%b i=%b, want 1 0", k, d_gnt, i_gnt);
            end
            @(posedge clk); #1;
        end
        i_req = 1; i_addr = 32'h20;
        @(negedge clk);
        checks++;
        if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL contest_after_data: got i=%b d=%b, want 1 0", i_gnt, d_gnt);
        end
        @(posedge clk); #1 i_req = 0;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1 || i_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL contest_followup: got d_gnt=%b i_rvalid=%b, want 1 1", d_gnt, i_rvalid);
        end
        @(posedge clk); #1 idle();
    endtask

    task automatic test_random();
        logic        pi, pd, pdwe, last_d, gi, gd, mis, ei, ed;
        logic [31:0] pia, pda, pdw, li, ld;
        logic [3:0]  pds, exp_we;
        int          idx;
        do_reset();
        for (int w = 0; w < (1 << AW); w++) begin
            ram[w] = $urandom;
            model_mem[w] = ram[w];
        end
        pi = 0; pd = 0; pdwe = 0; pia = '0; pda = '0; pdw = '0; pds = '0;
        last_d = 1; ei = 0; ed = 0; li = '0; ld = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pi && $urandom_range(0, 1) == 1) begin
                pi = 1; pia = $urandom;
            end
            if (!pd && $urandom_range(0, 1) == 1) begin
                pd = 1; pda = $urandom; pdwe = $urandom_range(0, 1);
                pds = strbs[$urandom_range(0, 6)]; pdw = $urandom;
            end
            i_req = pi; i_addr = pia; d_req = pd; d_addr = pda; d_we = pdwe; d_wstrb = pds; d_wdata = pdw;
            @(negedge clk);
            gi = pi && (!pd || last_d);
            gd = pd && !gi;
            mis = (pds == 4'hF && (pda % 4) != 0) || ((pds == 4'h3 || pds == 4'hC) && (pda % 2) != 0);
            exp_we = (gd && !mis && pdwe) ? pds : 4'h0;
            checks++;
            if (i_gnt !== gi || d_gnt !== gd || d_err !== (gd && mis) || mem_en !== (gi || (gd && !mis)) ||
                mem_we !== exp_we) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got gnt=%b%b err=%b en=%b we=%h, want %b%b %b %b %h",
                         c, i_gnt, d_gnt, d_err, mem_en, mem_we, gi, gd, gd && mis, gi || (gd && !mis), exp_we);
            end
            checks++;
            if (i_rvalid !== ei || d_rvalid !== ed || i_rdata !== li || d_rdata !== ld) begin
                errors++;
                $display("FAIL rand_read[%0d]: got rv=%b%b data=%h/%h, want %b%b %h/%h",
                         c, i_rvalid, d_rvalid, i_rdata, d_rdata, ei, ed, li, ld);
            end
            ei = 0; ed = 0;
            if (gi) begin
                idx = (pia / 4) % (1 << AW);
                ei = 1; li = model_mem[idx]; last_d = 0; pi = 0;
            end
            if (gd) begin
                idx = (pda / 4) % (1 << AW);
                last_d = 1; pd = 0;
                if (!mis && pdwe) begin
                    for (int b = 0; b < 4; b++)
                        if (pds[b]) model_mem[idx][8*b +: 8] = pdw[8*b +: 8];
                end else if (!mis) begin
                    ed = 1; ld = model_mem[idx];
                end
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    initial begin
        idle();
        resetn = 0;
        test_reset();
        test_fetch();
        test_contested();
        test_byte_write();
        test_misaligned();
        test_reset_after_grant();
        test_data_then_contest();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
